systolic_matmul_array: RTL
==========================

Name: systolic_matmul_array

Overview:
Parametrised successor to the fixed square systolic matrix multiply unit. It computes C = A x B, with A of size ROWS x K_LEN and B of size K_LEN x COLS, on an output-stationary ROWS x COLS grid of MAC cells.
- Built-in operand skewing, so callers feed unskewed vectors.
- Valid/ready streaming input with bubble tolerance.
- Runtime reduction length and a signed/unsigned mode.
- Row-by-row result drain with backpressure.
- Sits between the operand buffers and the accumulator/activation stage.

Parameters:
WIDTH, 8, operand width in bits.
ROWS, 4, grid rows; must be >= 2.
COLS, 4, grid columns; must be >= 2.
K_MAX, 256, maximum reduction length.
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
ACC_WIDTH, 2*WIDTH+$clog2(K_MAX), accumulator and result width.

Ports:
CLK  in  1  clock, rising edge.
ASYNC_RST  in  1  asynchronous active-high reset.
SYNC_RST  in  1  synchronous active-high reset; same effect as ASYNC_RST, applied at the clock edge.
START  in  1  begin an operation; sampled only in IDLE.
K_LEN  in  $clog2(K_MAX+1)  reduction length, latched on accepted START; values > K_MAX are treated as K_MAX.
IN_VALID  in  1  operand beat valid.
IN_READY  out  1  operand beat accepted when IN_VALID & IN_READY.
Inputs  in  WIDTH x ROWS (unpacked [0:ROWS-1])  column k of A; Inputs[r] = A[r][k].
Weights  in  WIDTH x COLS (unpacked [0:COLS-1])  row k of B; Weights[c] = B[k][c].
OUT_VALID  out  1  result row valid.
OUT_READY  in  1  result row consumed when OUT_VALID & OUT_READY.
OUT_ROW  out  $clog2(ROWS)  index of the row currently presented.
Result  out  ACC_WIDTH x COLS (unpacked [0:COLS-1])  Result[c] = C[OUT_ROW][c].
BUSY  out  1  high whenever state != IDLE.
DONE  out  1  one-cycle pulse after the last row handshake.

Behaviour:
- Reset (async or sync):
  - State goes to IDLE.
  - Accumulators, skew and pipeline registers, valid tags, beat counter and row counter all clear to 0.
  - All outputs are 0.
  - Reset mid-operation aborts the operation with no residue.
- Datapath:
  - Row r input passes through r skew registers; column c weight passes through c skew registers.
  - Each cell registers its operand right/down, 1 cycle per hop, together with a valid tag.
  - A cell accumulates only when the tag is set; product is sign-extended (SIGNED=1) or zero-extended to ACC_WIDTH.
  - Accumulator overflow wraps, although it is unreachable for K_LEN <= K_MAX.
  - Beat accepted at edge e is accumulated in cell [r][c] at edge e+r+c+1.
  - The pipeline advances every cycle; idle cycles inject tag=0 bubbles.
- FSM:
  - IDLE: IN_READY=0, OUT_VALID=0. On START, clear accumulators and latch K_LEN. If K_LEN == 0 go to DRAIN, else go to LOAD. START in any other state is ignored.
  - LOAD: IN_READY=1. Count accepted beats; on the K_LEN-th accepted beat go to FLUSH. IN_VALID low only inserts bubbles, with no timing penalty beyond the gap.
  - FLUSH: IN_READY=0 for exactly ROWS+COLS-1 cycles, then go to DRAIN. At that point the final accumulation into cell [ROWS-1][COLS-1] is complete.
  - DRAIN: OUT_VALID=1 and OUT_ROW starts at 0. Result is a mux of accumulator row OUT_ROW. OUT_ROW increments on each handshake. While OUT_READY=0, OUT_VALID, OUT_ROW and Result hold stable.
  - On the handshake of row ROWS-1: DONE=1 for one cycle, go to IDLE, OUT_VALID=0 next cycle.
- Accumulators hold their values in IDLE until the next START; they are not observable there.
- Latency from last accepted beat to first OUT_VALID is ROWS+COLS-1 cycles.

Test Plan:
1. Identity check. ROWS=COLS=4, K_LEN=4, A = I, B = 1..16 row-major, IN_VALID constant. Required: rows 0..3 = {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}. First OUT_VALID comes exactly 7 cycles after the last beat. DONE pulses once.
2. Signed extreme. SIGNED=1, K_LEN=256, all operands -128. Required: every Result = 4194304 (0x400000), with no wrap.
3. Bubbles. Same data as test 1, but IN_VALID toggles every cycle. Required: identical results. IN_READY stays 1 through LOAD. FLUSH starts at the 4th accepted beat.
4. Drain backpressure. Hold OUT_READY=0 for 3 cycles while OUT_ROW=1. Required: OUT_ROW, Result and OUT_VALID stay stable. DONE asserts only the cycle after the row-3 handshake.
5. Zero length and ignored START. K_LEN=0, then START pulsed during DRAIN. Required: no LOAD phase, 4 all-zero rows, a single DONE, and the second START has no effect.
6. Reset mid-operation. Assert ASYNC_RST after 2 of 4 LOAD beats. Required: BUSY, IN_READY and OUT_VALID drop to 0 immediately, with no clock. Rerunning test 1 afterwards gives exact results with no stale partial sums.

Source files
------------

// File: rtl/systolic_matmul_array.sv
// Output-stationary systolic matrix multiplier: C = A x B on a ROWS x COLS MAC grid
// with built-in operand skew, streaming operand input and row-by-row drain.
module systolic_matmul_array #(
   parameter int WIDTH     = 8,
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int K_MAX     = 256,
   parameter int SIGNED    = 1,
   parameter int ACC_WIDTH = 2*WIDTH+$clog2(K_MAX),
   localparam int KW       = $clog2(K_MAX+1),
   localparam int RW       = $clog2(ROWS)
) (
   input  logic                 CLK,
   input  logic                 ASYNC_RST,
   input  logic                 SYNC_RST,
   input  logic                 START,
   input  logic [KW-1:0]        K_LEN,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [WIDTH-1:0]     Inputs [0:ROWS-1],
   input  logic [WIDTH-1:0]     Weights [0:COLS-1],
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [RW-1:0]        OUT_ROW,
   output logic [ACC_WIDTH-1:0] Result [0:COLS-1],
   output logic                 BUSY,
   output logic                 DONE
);

   localparam int FW = $clog2(ROWS+COLS);
   localparam int FLUSH_LAST = ROWS+COLS-2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]    state;
   logic [KW-1:0] k_len_q;
   logic [KW-1:0] beat_cnt;
   logic [KW-1:0] k_eff;
   logic [FW-1:0] flush_cnt;
   logic [RW-1:0] row_q;
   logic          done_q;
   logic          fire;
   logic          acc_clr;

   logic [WIDTH-1:0]     a_cell [ROWS][COLS];
   logic [WIDTH-1:0]     b_cell [ROWS][COLS];
   logic                 t_cell [ROWS][COLS];
   logic [ACC_WIDTH-1:0] acc_q  [ROWS][COLS];

   assign IN_READY  = (state == S_LOAD);
   assign OUT_VALID = (state == S_DRAIN);
   assign BUSY      = (state != S_IDLE);
   assign DONE      = done_q;
   assign OUT_ROW   = row_q;
   assign fire      = IN_VALID & IN_READY;
   assign acc_clr   = (state == S_IDLE) & START;
   assign k_eff     = (K_LEN > KW'(K_MAX)) ? KW'(K_MAX) : K_LEN;

   always_ff @(posedge CLK or posedge ASYNC_RST) begin
      if (ASYNC_RST) begin
         state     <= S_IDLE;
         k_len_q   <= '0;
         beat_cnt  <= '0;
         flush_cnt <= '0;
         row_q     <= '0;
         done_q    <= 1'b0;
      end else if (SYNC_RST) begin
         state     <= S_IDLE;
         k_len_q   <= '0;
         beat_cnt  <= '0;
         flush_cnt <= '0;
         row_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (START) begin
                  k_len_q  <= k_eff;
                  beat_cnt <= '0;
                  row_q    <= '0;
                  state    <= (k_eff == '0) ? S_DRAIN : S_LOAD;
               end
            end
            S_LOAD: begin
               if (fire) begin
                  beat_cnt <= beat_cnt + KW'(1);
                  if (beat_cnt + KW'(1) == k_len_q) begin
                     state     <= S_FLUSH;
                     flush_cnt <= '0;
                  end
               end
            end
            S_FLUSH: begin
               // Wait for the last beat to reach the far corner cell
               if (flush_cnt == FW'(FLUSH_LAST)) state <= S_DRAIN;
               else flush_cnt <= flush_cnt + FW'(1);
            end
            default: begin
               if (OUT_READY) begin
                  if (row_q == RW'(ROWS-1)) begin
                     row_q  <= '0;
                     state  <= S_IDLE;
                     done_q <= 1'b1;
                  end else begin
                     row_q <= row_q + RW'(1);
                  end
               end
            end
         endcase
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam int L = r + COLS;
      logic [WIDTH-1:0] a_line [0:L-1];
      logic             t_line [0:L-1];
      // Slots 0..r-1 are skew, slot r+c is the register of cell [r][c]
      always_ff @(posedge CLK or posedge ASYNC_RST) begin
         if (ASYNC_RST) begin
            for (int i = 0; i < L; i++) begin
               a_line[i] <= '0;
               t_line[i] <= 1'b0;
            end
         end else if (SYNC_RST) begin
            for (int i = 0; i < L; i++) begin
               a_line[i] <= '0;
               t_line[i] <= 1'b0;
            end
         end else begin
            a_line[0] <= fire ? Inputs[r] : '0;
            t_line[0] <= fire;
            for (int i = 1; i < L; i++) begin
               a_line[i] <= a_line[i-1];
               t_line[i] <= t_line[i-1];
            end
         end
      end
      for (genvar c = 0; c < COLS; c++) begin : g_tap
         assign a_cell[r][c] = a_line[r+c];
         assign t_cell[r][c] = t_line[r+c];
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int L = c + ROWS;
      logic [WIDTH-1:0] b_line [0:L-1];
      always_ff @(posedge CLK or posedge ASYNC_RST) begin
         if (ASYNC_RST) begin
            for (int i = 0; i < L; i++) b_line[i] <= '0;
         end else if (SYNC_RST) begin
            for (int i = 0; i < L; i++) b_line[i] <= '0;
         end else begin
            b_line[0] <= fire ? Weights[c] : '0;
            for (int i = 1; i < L; i++) b_line[i] <= b_line[i-1];
         end
      end
      for (genvar r = 0; r < ROWS; r++) begin : g_tap
         assign b_cell[r][c] = b_line[c+r];
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_mr
      for (genvar c = 0; c < COLS; c++) begin : g_mc
         logic                 s_a;
         logic                 s_b;
         logic                 s_p;
         logic [2*WIDTH-1:0]   ax;
         logic [2*WIDTH-1:0]   bx;
         logic [2*WIDTH-1:0]   p;
         logic [ACC_WIDTH-1:0] prod;
         logic [ACC_WIDTH-1:0] acc;
         assign s_a  = (SIGNED != 0) & a_cell[r][c][WIDTH-1];
         assign s_b  = (SIGNED != 0) & b_cell[r][c][WIDTH-1];
         assign ax   = {{WIDTH{s_a}}, a_cell[r][c]};
         assign bx   = {{WIDTH{s_b}}, b_cell[r][c]};
         assign p    = ax * bx;
         assign s_p  = (SIGNED != 0) & p[2*WIDTH-1];
         assign prod = {{(ACC_WIDTH-2*WIDTH){s_p}}, p};
         always_ff @(posedge CLK or posedge ASYNC_RST) begin
            if (ASYNC_RST) acc <= '0;
            else if (SYNC_RST) acc <= '0;
            else if (acc_clr) acc <= '0;
            else if (t_cell[r][c]) acc <= acc + prod;
         end
         assign acc_q[r][c] = acc;
      end
   end

   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         Result[c] = OUT_VALID ? acc_q[row_q][c] : '0;
      end
   end

endmodule
